// File: rtl/calc2_pkg.sv
// Shared definitions for the calc2 port responder: command/response encodings,
// the response record carried through the exec pipes and queue, and the arithmetic helper.
package calc2_pkg;

    typedef enum logic [3:0] {
        CMD_IDLE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef struct packed {
        resp_e       resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } resp_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_e;

    localparam int ADD_LAT_DEF   = 1;
    localparam int SHIFT_LAT_DEF = 2;
    localparam int Q_DEPTH_DEF   = 4;

    function automatic logic is_shift(input logic [3:0] cmd);
        return (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

    // Error responses always carry zero data so the consumer never sees stale results.
    function automatic resp_t calc_exec(input logic [3:0]  cmd,
                                        input logic [31:0] op1,
                                        input logic [31:0] op2,
                                        input logic [1:0]  tag);
        resp_t       r;
        logic [32:0] sum;
        sum    = {1'b0, op1} + {1'b0, op2};
        r.resp = RESP_ERR;
        r.data = 32'd0;
        r.tag  = tag;
        case (cmd)
            CMD_ADD: begin
                if (!sum[32]) begin
                    r.resp = RESP_OK;
                    r.data = sum[31:0];
                end else begin
                    r.resp = RESP_ERR;
                end
            end
            CMD_SUB: begin
                if (op2 > op1) begin
                    r.resp = RESP_ERR;
                end else begin
                    r.resp = RESP_OK;
                    r.data = op1 - op2;
                end
            end
            CMD_SHL: begin
                r.resp = RESP_OK;
                r.data = op1 << op2[4:0];
            end
            CMD_SHR: begin
                r.resp = RESP_OK;
                r.data = op1 >> op2[4:0];
            end
            default: r.resp = RESP_ERR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/calc2_resp_fifo.sv
// Response queue with two write ports (wr0 lands ahead of wr1) and one read port.
// Occupancy is tracked by a separate count so every slot is usable.
module calc2_resp_fifo
    import calc2_pkg::*;
#(
    parameter  int DEPTH = Q_DEPTH_DEF,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr0_en,
    input  resp_t         wr0_data,
    input  logic          wr1_en,
    input  resp_t         wr1_data,
    input  logic          rd_en,
    output resp_t         rd_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    resp_t         mem_q [DEPTH];
    resp_t         mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wp1_s;
    logic [CW-1:0] count_q, count_d;
    logic          do_rd_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_rd_s  = rd_en && (count_q != '0);
        wp1_s    = wr0_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        wr_ptr_d = wr1_en ? ptr_inc(wp1_s) : wp1_s;
        rd_ptr_d = do_rd_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(do_rd_s);
        for (int i = 0; i < DEPTH; i++) begin
            if (wr0_en && (wr_ptr_q == PW'(i))) begin
                mem_d[i] = wr0_data;
            end else if (wr1_en && (wp1_s == PW'(i))) begin
                mem_d[i] = wr1_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

    calc2_resp_fifo_chk #(.DEPTH(DEPTH)) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .count  (count_q),
        .wr0_en (wr0_en),
        .wr1_en (wr1_en),
        .rd_en  (do_rd_s)
    );

endmodule

// Overflow of the response queue means the outstanding limit was bypassed.
module calc2_resp_fifo_chk #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic          wr0_en,
    input logic          wr1_en,
    input logic          rd_en
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(count) + int'(wr0_en) + int'(wr1_en) - int'(rd_en)) <= DEPTH);

endmodule

// File: rtl/calc2_port_responder.sv
// Responder for one calc2 port: two-cycle request capture, latency-matched exec pipes,
// response queue and a registered output stage; requests beyond the outstanding limit are dropped.
module calc2_port_responder
    import calc2_pkg::*;
#(
    parameter int ADD_LAT   = ADD_LAT_DEF,
    parameter int SHIFT_LAT = SHIFT_LAT_DEF,
    parameter int Q_DEPTH   = Q_DEPTH_DEF
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  cmd_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  tag_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic [1:0]  out_tag,
    output logic        err_drop
);

    localparam int CW = $clog2(Q_DEPTH + 1);
    localparam int OW = $clog2(Q_DEPTH + ADD_LAT + SHIFT_LAT + 1);

    state_e               state_q, state_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [1:0]           tag_q, tag_d;
    logic [31:0]          op1_q, op1_d;
    logic                 err_drop_q, err_drop_d;
    logic [ADD_LAT-1:0]   sp_vld_q, sp_vld_d;
    resp_t                sp_ent_q [ADD_LAT];
    resp_t                sp_ent_d [ADD_LAT];
    logic [SHIFT_LAT-1:0] lp_vld_q, lp_vld_d;
    resp_t                lp_ent_q [SHIFT_LAT];
    resp_t                lp_ent_d [SHIFT_LAT];
    resp_t                out_q, out_d;

    logic                 issue_s, shift_s, fifo_empty_s;
    resp_t                exec_s, fifo_rd_s;
    logic [CW-1:0]        fifo_count_s;
    logic [OW-1:0]        outstanding_s;

    assign exec_s  = calc_exec(cmd_q, op1_q, data_in, tag_q);
    assign shift_s = is_shift(cmd_q);

    // Outstanding work: everything still in a pipe or waiting in the queue.
    always_comb begin
        outstanding_s = OW'(fifo_count_s);
        for (int i = 0; i < ADD_LAT; i++) begin
            outstanding_s = outstanding_s + OW'(sp_vld_q[i]);
        end
        for (int i = 0; i < SHIFT_LAT; i++) begin
            outstanding_s = outstanding_s + OW'(lp_vld_q[i]);
        end
    end

    // Request FSM; the drop decision is taken on the cmd cycle so err_drop shows in the op2 cycle.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        tag_d      = tag_q;
        op1_d      = op1_q;
        err_drop_d = 1'b0;
        issue_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_in != 4'd0) begin
                    cmd_d      = cmd_in;
                    tag_d      = tag_in;
                    op1_d      = data_in;
                    err_drop_d = (outstanding_s >= OW'(Q_DEPTH));
                    state_d    = ST_OP2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OP2: begin
                issue_s = !err_drop_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Exec pipes: the result is computed at issue and delayed to match the command latency.
    always_comb begin
        sp_vld_d[0] = issue_s && !shift_s;
        sp_ent_d[0] = exec_s;
        for (int i = 1; i < ADD_LAT; i++) begin
            sp_vld_d[i] = sp_vld_q[i-1];
            sp_ent_d[i] = sp_ent_q[i-1];
        end
        lp_vld_d[0] = issue_s && shift_s;
        lp_ent_d[0] = exec_s;
        for (int i = 1; i < SHIFT_LAT; i++) begin
            lp_vld_d[i] = lp_vld_q[i-1];
            lp_ent_d[i] = lp_ent_q[i-1];
        end
    end

    // Output stage presents one queued response per cycle, zero otherwise.
    always_comb begin
        if (fifo_empty_s) begin
            out_d = '0;
        end else begin
            out_d = fifo_rd_s;
        end
    end

    // All responder state; reset flushes in-flight work without responding.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 4'd0;
            tag_q      <= 2'd0;
            op1_q      <= 32'd0;
            err_drop_q <= 1'b0;
            sp_vld_q   <= '0;
            lp_vld_q   <= '0;
            out_q      <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                sp_ent_q[i] <= '0;
            end
            for (int i = 0; i < SHIFT_LAT; i++) begin
                lp_ent_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            tag_q      <= tag_d;
            op1_q      <= op1_d;
            err_drop_q <= err_drop_d;
            sp_vld_q   <= sp_vld_d;
            lp_vld_q   <= lp_vld_d;
            out_q      <= out_d;
            for (int i = 0; i < ADD_LAT; i++) begin
                sp_ent_q[i] <= sp_ent_d[i];
            end
            for (int i = 0; i < SHIFT_LAT; i++) begin
                lp_ent_q[i] <= lp_ent_d[i];
            end
        end
    end

    // Issue is at most every other cycle and SHIFT_LAT >= ADD_LAT, so when both pipes
    // complete on one edge the long-pipe entry is always the older one: it takes wr0.
    calc2_resp_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
        .clk      (c_clk),
        .rst_n    (reset),
        .wr0_en   (lp_vld_q[SHIFT_LAT-1]),
        .wr0_data (lp_ent_q[SHIFT_LAT-1]),
        .wr1_en   (sp_vld_q[ADD_LAT-1]),
        .wr1_data (sp_ent_q[ADD_LAT-1]),
        .rd_en    (!fifo_empty_s),
        .rd_data  (fifo_rd_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    assign out_resp = out_q.resp;
    assign out_data = out_q.data;
    assign out_tag  = out_q.tag;
    assign err_drop = err_drop_q;

endmodule
